// File: rtl/dhsm_fifo_responder.sv
// Memory-side responder for the datagram-handler fifo interface: reads go straight to RAM,
// writes are posted into a frame buffer and committed only when the frame ends cleanly.
module dhsm_fifo_responder #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_sof,
    input  logic              fifo_eof,
    input  logic              fifo_valid,
    input  logic              fifo_read,
    input  logic [15:0]       fifo_addr,
    input  logic [7:0]        fifo_wdata,
    output logic [7:0]        fifo_rdata,
    output logic              fifo_ready,
    input  logic              frame_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_gnt,
    input  logic [7:0]        mem_rdata,
    output logic              commit_done,
    output logic              frame_drop
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_FRAME, S_RD_REQ, S_RD_DAT, S_COMMIT, S_DROP
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               eof_pend_q, eof_pend_d, err_pend_q, err_pend_d, sof_pend_q, sof_pend_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               rd_oor_q, rd_oor_d;
    logic               done_q, done_d;
    logic               push;
    logic               in_rng;
    logic [ADDR_W+7:0]  buf_mem [DEPTH];
    logic [ADDR_W+7:0]  head;

    assign in_rng = ((32'(fifo_addr) >> ADDR_W) == 32'd0);
    assign head   = buf_mem[rd_ptr_q];

    // Good frames with at least one buffered byte commit; everything else is discarded.
    function automatic state_t eof_target(input logic [CNT_W-1:0] cnt, input logic ovf,
                                          input logic err);
        return (!err && !ovf && cnt != '0) ? S_COMMIT : S_DROP;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            eof_pend_q <= 1'b0;
            err_pend_q <= 1'b0;
            sof_pend_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_oor_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            eof_pend_q <= eof_pend_d;
            err_pend_q <= err_pend_d;
            sof_pend_q <= sof_pend_d;
            rd_addr_q  <= rd_addr_d;
            rd_oor_q   <= rd_oor_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) buf_mem[wr_ptr_q] <= {fifo_addr[ADDR_W-1:0], fifo_wdata};
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        eof_pend_d = eof_pend_q;
        err_pend_d = err_pend_q;
        sof_pend_d = sof_pend_q;
        rd_addr_d  = rd_addr_q;
        rd_oor_d   = rd_oor_q;
        done_d     = 1'b0;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fifo_sof && !fifo_eof) begin
                    state_d  = S_FRAME;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                end
            end
            S_FRAME: begin
                if (fifo_valid && !fifo_read && in_rng) begin
                    if (cnt_q != FULL) begin
                        push     = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (fifo_valid && fifo_read) begin
                    state_d   = S_RD_REQ;
                    rd_addr_d = fifo_addr[ADDR_W-1:0];
                    rd_oor_d  = !in_rng;
                    if (fifo_eof) begin
                        eof_pend_d = 1'b1;
                        err_pend_d = frame_err;
                    end
                    if (fifo_sof) sof_pend_d = 1'b1;
                end else if (fifo_eof) begin
                    state_d = eof_target(cnt_d, ovf_d, frame_err);
                    if (fifo_sof) sof_pend_d = 1'b1;
                end else if (fifo_sof) begin
                    state_d    = S_DROP;
                    sof_pend_d = 1'b1;
                end
            end
            S_RD_REQ, S_RD_DAT: begin
                // Frame events arriving mid-read are held until the read has returned.
                if (fifo_eof) begin
                    eof_pend_d = 1'b1;
                    err_pend_d = frame_err;
                end
                if (fifo_sof) sof_pend_d = 1'b1;
                if (state_q == S_RD_REQ) begin
                    if (rd_oor_q || mem_gnt) state_d = S_RD_DAT;
                end else if (eof_pend_d) begin
                    state_d    = eof_target(cnt_q, ovf_q, err_pend_d);
                    eof_pend_d = 1'b0;
                end else if (sof_pend_d) begin
                    state_d = S_DROP;
                end else begin
                    state_d = S_FRAME;
                end
            end
            S_COMMIT: begin
                if (fifo_sof) sof_pend_d = 1'b1;
                if (mem_gnt) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        done_d     = 1'b1;
                        state_d    = sof_pend_d ? S_FRAME : S_IDLE;
                        sof_pend_d = 1'b0;
                    end
                end
            end
            S_DROP: begin
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                cnt_d      = '0;
                ovf_d      = 1'b0;
                state_d    = (sof_pend_q || fifo_sof) ? S_FRAME : S_IDLE;
                sof_pend_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = 8'h00;
        fifo_ready  = 1'b0;
        fifo_rdata  = 8'h00;
        frame_drop  = 1'b0;
        commit_done = done_q;
        case (state_q)
            S_RD_REQ: begin
                mem_req  = !rd_oor_q;
                mem_addr = rd_addr_q;
            end
            S_RD_DAT: begin
                fifo_ready = 1'b1;
                fifo_rdata = rd_oor_q ? 8'h00 : mem_rdata;
            end
            S_COMMIT: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head[ADDR_W+7:8];
                mem_wdata = head[7:0];
            end
            S_DROP: frame_drop = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dhsm_fifo_responder.sv
// Randomized scoreboard bench: a frame-level model predicts reads, RAM writes and frame outcomes.
module tb_dhsm_fifo_responder;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 64;
    localparam int MSIZE  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              fifo_sof, fifo_eof, fifo_valid, fifo_read, frame_err;
    logic [15:0]       fifo_addr;
    logic [7:0]        fifo_wdata, fifo_rdata;
    logic              fifo_ready;
    logic              mem_req, mem_we, mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata, mem_rdata;
    logic              commit_done, frame_drop;

    dhsm_fifo_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .fifo_sof(fifo_sof), .fifo_eof(fifo_eof),
        .fifo_valid(fifo_valid), .fifo_read(fifo_read), .fifo_addr(fifo_addr),
        .fifo_wdata(fifo_wdata), .fifo_rdata(fifo_rdata), .fifo_ready(fifo_ready),
        .frame_err(frame_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
        .commit_done(commit_done), .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Environment RAM (the arbiter + memory the DUT talks to).
    logic [7:0] env_ram [MSIZE];
    // Reference model state.
    logic [7:0]  ref_ram [MSIZE];
    logic [19:0] m_buf[$];
    bit          m_ovf;
    bit          in_frame;
    logic [7:0]  exp_rd[$];
    logic [19:0] exp_wr[$];
    int          exp_evt[$];   // 1 = commit_done, 2 = frame_drop
    int          gnt_block = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst && mem_req && mem_gnt) begin
            if (mem_we) env_ram[mem_addr] = mem_wdata;
            else        mem_rdata <= env_ram[mem_addr];
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (gnt_block > 0) begin
            mem_gnt = 1'b0;
            gnt_block--;
        end else begin
            mem_gnt = ($urandom_range(0, 99) < 60);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents something.
    logic              p_req = 1'b0, p_gnt = 1'b0, p_we = 1'b0;
    logic [ADDR_W-1:0] p_addr = '0;
    logic [7:0]        p_wdata = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (p_req && !p_gnt)
                check("req_stable", {mem_req, mem_we, 4'h0, mem_addr, mem_wdata},
                      {1'b1, p_we, 4'h0, p_addr, p_wdata});
            if (p_req && p_gnt && !p_we)
                check("ready_after_gnt", 32'(fifo_ready), 32'd1);
            if (fifo_ready) begin
                if (exp_rd.size() == 0) check("unexpected_ready", 32'd1, 32'd0);
                else check("rdata", 32'(fifo_rdata), 32'(exp_rd.pop_front()));
            end
            if (mem_req && mem_gnt && mem_we) begin
                if (exp_wr.size() == 0) check("unexpected_ram_write", 32'(mem_addr), 32'hFFFFFFFF);
                else check("ram_write", 32'({mem_addr, mem_wdata}), 32'(exp_wr.pop_front()));
            end
            if (commit_done || frame_drop) begin
                if (exp_evt.size() == 0) check("unexpected_pulse", {30'd0, frame_drop, commit_done}, 32'd0);
                else check("frame_outcome", frame_drop ? 32'd2 : 32'd1, 32'(exp_evt.pop_front()));
            end
        end
        p_req = mem_req; p_gnt = mem_gnt; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
    end

    task automatic cyc(input logic sof, input logic eof, input logic vld, input logic rd,
                       input logic [15:0] a, input logic [7:0] d, input logic err);
        @(posedge clk);
        #1;
        fifo_sof = sof; fifo_eof = eof; fifo_valid = vld; fifo_read = rd;
        fifo_addr = a; fifo_wdata = d; frame_err = err;
    endtask

    task automatic idle(); cyc(0, 0, 0, 0, 16'h0, 8'h0, 0); endtask

    task automatic wait_ready();
        bit seen = 0;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge clk);
            if (fifo_ready) seen = 1;
        end
        if (!seen) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_evt();
        bit seen = 0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk);
            if (commit_done || frame_drop) seen = 1;
        end
        if (!seen) check("outcome_timeout", 32'd0, 32'd1);
    endtask

    // Frame-level rules: a clean, non-overflowed, non-empty frame writes its bytes in order.
    task automatic model_eof(input logic err);
        if (!err && !m_ovf && m_buf.size() > 0) begin
            foreach (m_buf[i]) begin
                exp_wr.push_back(m_buf[i]);
                ref_ram[m_buf[i][19:8]] = m_buf[i][7:0];
            end
            exp_evt.push_back(1);
        end else begin
            exp_evt.push_back(2);
        end
        m_buf.delete();
        m_ovf = 0;
        in_frame = 0;
    endtask

    task automatic do_sof();
        if (in_frame) exp_evt.push_back(2);
        m_buf.delete();
        m_ovf = 0;
        in_frame = 1;
        cyc(1, 0, 0, 0, 16'h0, 8'h0, 0);
        idle();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        if (int'(a) < MSIZE) begin
            if (m_buf.size() < DEPTH) m_buf.push_back({a[ADDR_W-1:0], d});
            else m_ovf = 1;
        end
        cyc(0, 0, 1, 0, a, d, 0);
    endtask

    task automatic do_read(input logic [15:0] a);
        exp_rd.push_back(int'(a) < MSIZE ? ref_ram[a[ADDR_W-1:0]] : 8'h00);
        cyc(0, 0, 1, 1, a, 8'h0, 0);
        idle();
        wait_ready();
    endtask

    task automatic do_eof(input logic err);
        model_eof(err);
        cyc(0, 1, 0, 0, 16'h0, 8'h0, err);
        idle();
        wait_evt();
    endtask

    function automatic logic [15:0] rnd_addr();
        if ($urandom_range(0, 9) == 0) return 16'($urandom_range(MSIZE, 16'hFFFF));
        return 16'($urandom_range(0, 63));
    endfunction

    initial begin
        for (int i = 0; i < MSIZE; i++) begin
            env_ram[i] = 8'($urandom);
            ref_ram[i] = env_ram[i];
        end
        rst = 1'b1;
        fifo_sof = 0; fifo_eof = 0; fifo_valid = 0; fifo_read = 0;
        fifo_addr = '0; fifo_wdata = '0; frame_err = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_ready", 32'(fifo_ready), 32'd0);
        check("rst_pulses", {30'd0, commit_done, frame_drop}, 32'd0);
        check("rst_rdata", 32'(fifo_rdata), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic commit of two bytes in order.
        do_sof();
        do_write(16'h010, 8'hAA);
        do_write(16'h011, 8'hBB);
        do_eof(0);

        // Read sees pre-frame contents; write lands after eof.
        ref_ram[12'h020] = 8'h5A;
        env_ram[12'h020] = 8'h5A;
        do_sof();
        do_write(16'h020, 8'h11);
        do_read(16'h020);
        do_eof(0);
        do_sof();
        do_read(16'h020);
        do_eof(1);

        // Errored frame is discarded.
        do_sof();
        do_write(16'h030, 8'h01); do_write(16'h031, 8'h02); do_write(16'h032, 8'h03);
        do_eof(1);

        // Overflow by one byte drops the frame; the next good frame commits.
        do_sof();
        for (int i = 0; i < DEPTH + 1; i++) do_write(16'(16'h100 + i), 8'(i));
        do_eof(0);
        do_sof();
        do_write(16'h040, 8'hC3);
        do_write(16'h040, 8'h3C);
        do_eof(0);

        // Grant stall during a read, then an out-of-range read.
        do_sof();
        gnt_block = 6;
        do_read(16'h011);
        do_read(16'h1FFF);
        do_eof(1);

        // sof arriving during a four-byte commit.
        do_sof();
        for (int i = 0; i < 4; i++) do_write(16'(16'h050 + i), 8'(8'hE0 + i));
        model_eof(0);
        in_frame = 1;
        gnt_block = 2;
        cyc(0, 1, 0, 0, 16'h0, 8'h0, 0);
        cyc(1, 0, 0, 0, 16'h0, 8'h0, 0);
        idle();
        wait_evt();
        do_write(16'h058, 8'h77);
        do_eof(0);

        // sof and eof together from idle: an empty frame with no outcome pulse.
        cyc(1, 1, 0, 0, 16'h0, 8'h0, 0);
        repeat (5) idle();

        // Read coincident with eof, and eof arriving while a read is stalled.
        do_sof();
        do_write(16'h060, 8'h99);
        exp_rd.push_back(ref_ram[12'h060]);
        model_eof(0);
        cyc(0, 1, 1, 1, 16'h060, 8'h0, 0);
        idle();
        wait_ready();
        wait_evt();
        do_sof();
        do_write(16'h061, 8'h42);
        exp_rd.push_back(ref_ram[12'h061]);
        model_eof(0);
        gnt_block = 4;
        cyc(0, 0, 1, 1, 16'h061, 8'h0, 0);
        cyc(0, 1, 0, 0, 16'h0, 8'h0, 0);
        idle();
        wait_ready();
        wait_evt();

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            if (!in_frame || $urandom_range(0, 9) == 0) do_sof();
            for (int n = 0; n < int'($urandom_range(1, 10)); n++) begin
                if ($urandom_range(0, 3) == 0) do_read(rnd_addr());
                else do_write(rnd_addr(), 8'($urandom));
            end
            if ($urandom_range(0, 9) != 0) do_eof($urandom_range(0, 3) == 0);
        end
        if (in_frame) do_eof(0);
        repeat (10) idle();

        check("exp_rd_left", 32'(exp_rd.size()), 32'd0);
        check("exp_wr_left", 32'(exp_wr.size()), 32'd0);
        check("exp_evt_left", 32'(exp_evt.size()), 32'd0);
        begin
            int bad = 0;
            for (int i = 0; i < MSIZE; i++) if (env_ram[i] !== ref_ram[i]) bad++;
            check("ram_image", 32'(bad), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
